// File: rtl/processor_top.sv
// processor_top: 5-stage in-order RV32I pipeline (IF ID EX MEM WB) with
// IMEM, register file, DMEM, EX forwarding and a load-use stall.
// Ports: clk (rising edge), rst (async, active high).

package processor_pkg;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
    ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA
  } alu_op_t;

  typedef struct packed {
    logic [31:0] instr;
  } if_id_t;

  typedef struct packed {
    alu_op_t     alu_op;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic        use_imm;
    logic        reg_we;
    logic        mem_re;
    logic        mem_we;
  } id_ex_t;

  typedef struct packed {
    logic [31:0] alu_res;
    logic [31:0] store_data;
    logic [4:0]  rd;
    logic        reg_we;
    logic        mem_re;
    logic        mem_we;
  } ex_mem_t;

  typedef struct packed {
    logic [31:0] wb_data;
    logic [4:0]  rd;
    logic        reg_we;
  } mem_wb_t;

endpackage

// imem: 256-word instruction store, combinational read.
// Ports: addr (word index), rdata.
module imem (
  input  logic [7:0]  addr,
  output logic [31:0] rdata
);

  // Zero only at time 0; contents are preloaded from outside and
  // must survive reset.
  logic [31:0] mem_array [0:255] = '{default: '0};

  assign rdata = mem_array[addr];

endmodule

// reg_file: 32 x 32 registers, two read ports, one write port.
// Ports: clk, rst, raddr1/2, rdata1/2, we, waddr, wdata.
module reg_file (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata
);

  logic [31:0] registers [0:31];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) registers[i] <= '0;
    end else if (we && waddr != 5'd0) begin
      registers[waddr] <= wdata;
    end
  end

  // Write-through so a same-cycle WB is seen by ID.
  always_comb begin
    rdata1 = registers[raddr1];
    rdata2 = registers[raddr2];
    if (we && waddr == raddr1) rdata1 = wdata;
    if (we && waddr == raddr2) rdata2 = wdata;
    if (raddr1 == 5'd0) rdata1 = '0;
    if (raddr2 == 5'd0) rdata2 = '0;
  end

endmodule

// id_stage: decode and register read.
// Ports: clk, rst, if_id, wb_we/wb_rd/wb_data, dec (next ID/EX).
module id_stage
  import processor_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  if_id_t      if_id,
  input  logic        wb_we,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output id_ex_t      dec
);

  logic [31:0] ins;
  logic [6:0]  opcode;
  logic [6:0]  f7;
  logic [2:0]  f3;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic        is_r;
  logic        is_i;
  logic        is_lw;
  logic        is_sw;

  assign ins    = if_id.instr;
  assign opcode = ins[6:0];
  assign rd     = ins[11:7];
  assign f3     = ins[14:12];
  assign rs1    = ins[19:15];
  assign rs2    = ins[24:20];
  assign f7     = ins[31:25];
  assign imm_i  = {{20{ins[31]}}, ins[31:20]};
  assign imm_s  = {{20{ins[31]}}, ins[31:25], ins[11:7]};

  assign is_r  = opcode == 7'b0110011;
  assign is_i  = opcode == 7'b0010011;
  assign is_lw = opcode == 7'b0000011 && f3 == 3'b010;
  assign is_sw = opcode == 7'b0100011 && f3 == 3'b010;

  reg_file reg_file_inst (
    .clk    (clk),
    .rst    (rst),
    .raddr1 (rs1),
    .raddr2 (rs2),
    .rdata1 (rs1_val),
    .rdata2 (rs2_val),
    .we     (wb_we),
    .waddr  (wb_rd),
    .wdata  (wb_data)
  );

  always_comb begin
    dec         = '0;
    dec.rs1     = rs1;
    dec.rs2     = rs2;
    dec.rd      = rd;
    dec.rs1_val = rs1_val;
    dec.rs2_val = rs2_val;
    unique case (1'b1)
      is_r: begin
        dec.reg_we = 1'b1;
        case ({f7, f3})
          10'b0000000_000: dec.alu_op = ALU_ADD;
          10'b0100000_000: dec.alu_op = ALU_SUB;
          10'b0000000_001: dec.alu_op = ALU_SLL;
          10'b0000000_010: dec.alu_op = ALU_SLT;
          10'b0000000_011: dec.alu_op = ALU_SLTU;
          10'b0000000_100: dec.alu_op = ALU_XOR;
          10'b0000000_101: dec.alu_op = ALU_SRL;
          10'b0100000_101: dec.alu_op = ALU_SRA;
          10'b0000000_110: dec.alu_op = ALU_OR;
          10'b0000000_111: dec.alu_op = ALU_AND;
          default:         dec.reg_we = 1'b0;
        endcase
      end
      is_i: begin
        dec.reg_we  = 1'b1;
        dec.use_imm = 1'b1;
        dec.imm     = imm_i;
        case (f3)
          3'b000: dec.alu_op = ALU_ADD;
          3'b010: dec.alu_op = ALU_SLT;
          3'b011: dec.alu_op = ALU_SLTU;
          3'b100: dec.alu_op = ALU_XOR;
          3'b110: dec.alu_op = ALU_OR;
          3'b111: dec.alu_op = ALU_AND;
          3'b001: begin
            dec.alu_op = ALU_SLL;
            if (f7 != 7'b0000000) dec.reg_we = 1'b0;
          end
          3'b101: begin
            if (f7 == 7'b0100000) dec.alu_op = ALU_SRA;
            else dec.alu_op = ALU_SRL;
            if (f7 != 7'b0000000 && f7 != 7'b0100000)
              dec.reg_we = 1'b0;
          end
        endcase
      end
      is_lw: begin
        dec.use_imm = 1'b1;
        dec.imm     = imm_i;
        dec.reg_we  = 1'b1;
        dec.mem_re  = 1'b1;
      end
      is_sw: begin
        dec.use_imm = 1'b1;
        dec.imm     = imm_s;
        dec.mem_we  = 1'b1;
      end
      default: ;
    endcase
    // x0 is never a destination, so forwarding never sees it.
    if (rd == 5'd0) dec.reg_we = 1'b0;
  end

endmodule

// processor_top: PC/IF, pipeline registers, EX with forwarding,
// MEM with DMEM, WB. Ports: clk, rst.
module processor_top
  import processor_pkg::*;
(
  input logic clk,
  input logic rst
);

  logic [7:0]  pc_q;
  logic [31:0] fetch_instr;
  if_id_t      if_id_q;
  id_ex_t      id_ex_q;
  id_ex_t      id_dec;
  ex_mem_t     ex_mem_q;
  ex_mem_t     ex_mem_d;
  mem_wb_t     mem_wb_q;
  mem_wb_t     mem_wb_d;
  logic        load_use;
  logic [31:0] fwd_a;
  logic [31:0] fwd_b;
  logic [31:0] op_b;
  logic [4:0]  shamt;
  logic [31:0] alu_res;
  logic [31:0] load_data;

  logic [31:0] dmem [0:255] = '{default: '0};

  imem imem_inst (
    .addr  (pc_q),
    .rdata (fetch_instr)
  );

  id_stage id_stage_inst (
    .clk     (clk),
    .rst     (rst),
    .if_id   (if_id_q),
    .wb_we   (mem_wb_q.reg_we),
    .wb_rd   (mem_wb_q.rd),
    .wb_data (mem_wb_q.wb_data),
    .dec     (id_dec)
  );

  // Raw rs fields are compared, whether or not the op uses them.
  assign load_use = id_ex_q.mem_re && id_ex_q.rd != 5'd0 &&
                    (id_ex_q.rd == if_id_q.instr[19:15] ||
                     id_ex_q.rd == if_id_q.instr[24:20]);

  function automatic logic [31:0] fwd(
    input logic [4:0]  src,
    input logic [31:0] rf_val,
    input ex_mem_t     em,
    input mem_wb_t     mw
  );
    if (em.reg_we && em.rd != 5'd0 && em.rd == src)
      return em.alu_res;
    if (mw.reg_we && mw.rd != 5'd0 && mw.rd == src)
      return mw.wb_data;
    return rf_val;
  endfunction

  assign fwd_a = fwd(id_ex_q.rs1, id_ex_q.rs1_val, ex_mem_q, mem_wb_q);
  assign fwd_b = fwd(id_ex_q.rs2, id_ex_q.rs2_val, ex_mem_q, mem_wb_q);
  assign op_b  = id_ex_q.use_imm ? id_ex_q.imm : fwd_b;
  assign shamt = op_b[4:0];

  always_comb begin
    alu_res = '0;
    unique case (id_ex_q.alu_op)
      ALU_ADD:  alu_res = fwd_a + op_b;
      ALU_SUB:  alu_res = fwd_a - op_b;
      ALU_AND:  alu_res = fwd_a & op_b;
      ALU_OR:   alu_res = fwd_a | op_b;
      ALU_XOR:  alu_res = fwd_a ^ op_b;
      ALU_SLT:  alu_res = {31'd0, $signed(fwd_a) < $signed(op_b)};
      ALU_SLTU: alu_res = {31'd0, fwd_a < op_b};
      ALU_SLL:  alu_res = fwd_a << shamt;
      ALU_SRL:  alu_res = fwd_a >> shamt;
      ALU_SRA:  alu_res = $signed(fwd_a) >>> shamt;
      default:  alu_res = '0;
    endcase
  end

  always_comb begin
    ex_mem_d            = '0;
    ex_mem_d.alu_res    = alu_res;
    ex_mem_d.store_data = fwd_b;
    ex_mem_d.rd         = id_ex_q.rd;
    ex_mem_d.reg_we     = id_ex_q.reg_we;
    ex_mem_d.mem_re     = id_ex_q.mem_re;
    ex_mem_d.mem_we     = id_ex_q.mem_we;
  end

  assign load_data = dmem[ex_mem_q.alu_res[9:2]];

  always_comb begin
    mem_wb_d         = '0;
    mem_wb_d.rd      = ex_mem_q.rd;
    mem_wb_d.reg_we  = ex_mem_q.reg_we;
    mem_wb_d.wb_data = ex_mem_q.mem_re ? load_data : ex_mem_q.alu_res;
  end

  // DMEM is not reset; its contents persist across rst.
  always_ff @(posedge clk) begin
    if (ex_mem_q.mem_we)
      dmem[ex_mem_q.alu_res[9:2]] <= ex_mem_q.store_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q     <= '0;
      if_id_q  <= '0;
      id_ex_q  <= '0;
      ex_mem_q <= '0;
      mem_wb_q <= '0;
    end else begin
      if (load_use) begin
        id_ex_q <= '0;
      end else begin
        pc_q          <= pc_q + 8'd1;
        if_id_q.instr <= fetch_instr;
        id_ex_q       <= id_dec;
      end
      ex_mem_q <= ex_mem_d;
      mem_wb_q <= mem_wb_d;
    end
  end

endmodule

// File: tb/tb_processor_top.sv
// tb_processor_top: scoreboard bench for processor_top; an ISA-level
// model predicts writebacks, a monitor checks them as they retire.
module tb_processor_top;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] val;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   edge_cnt = 0;
  wr_t  exp_q [$];
  wr_t  mon_e;
  int   wr_edge [$];
  logic [31:0] prog [$];
  logic [31:0] m_regs [32];
  logic [31:0] m_dmem [256];

  always #5 clk = ~clk;

  processor_top dut (
    .clk (clk),
    .rst (rst)
  );

  always @(posedge clk) begin
    if (rst) edge_cnt = 0;
    else edge_cnt++;
  end

  // Monitor: every retiring register write is popped and compared.
  always @(negedge clk) begin
    if (!rst && dut.id_stage_inst.reg_file_inst.we &&
        dut.id_stage_inst.reg_file_inst.waddr != 5'd0) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL wb_unexpected: got x%0d=%h, required no write",
                 dut.id_stage_inst.reg_file_inst.waddr,
                 dut.id_stage_inst.reg_file_inst.wdata);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.rd !== dut.id_stage_inst.reg_file_inst.waddr ||
            mon_e.val !== dut.id_stage_inst.reg_file_inst.wdata) begin
          failures++;
          $display("FAIL wb_stream: got x%0d=%h, required x%0d=%h",
                   dut.id_stage_inst.reg_file_inst.waddr,
                   dut.id_stage_inst.reg_file_inst.wdata,
                   mon_e.rd, mon_e.val);
        end
      end
      wr_edge.push_back(edge_cnt + 1);
    end
  end

  function automatic logic [31:0] enc_r(
    input logic [6:0] f7, input logic [4:0] rs2,
    input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  function automatic logic [31:0] enc_i(
    input logic [11:0] imm, input logic [4:0] rs1,
    input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(
    input logic [11:0] imm, input logic [4:0] rs2,
    input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] get_reg(input int i);
    return dut.id_stage_inst.reg_file_inst.registers[i];
  endfunction

  task automatic check32(input string name, input logic [31:0] act,
                         input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // ISA-level reference: executes the program in order.
  task automatic model_run();
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    foreach (prog[k]) begin
      logic [31:0] ins, a, b, res, immi, imms, addr;
      logic [4:0]  rd, sh;
      logic [2:0]  f3;
      logic [6:0]  f7;
      bit wr;
      ins  = prog[k];
      rd   = ins[11:7];
      f3   = ins[14:12];
      f7   = ins[31:25];
      a    = m_regs[ins[19:15]];
      b    = m_regs[ins[24:20]];
      immi = {{20{ins[31]}}, ins[31:20]};
      imms = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      wr   = 1'b0;
      res  = '0;
      case (ins[6:0])
        7'h33: begin
          sh = b[4:0];
          wr = 1'b1;
          case ({f7, f3})
            10'h000: res = a + b;
            10'h100: res = a - b;
            10'h001: res = a << sh;
            10'h002: res = {31'd0, $signed(a) < $signed(b)};
            10'h003: res = {31'd0, a < b};
            10'h004: res = a ^ b;
            10'h005: res = a >> sh;
            10'h105: res = $signed(a) >>> sh;
            10'h006: res = a | b;
            10'h007: res = a & b;
            default: wr = 1'b0;
          endcase
        end
        7'h13: begin
          sh = ins[24:20];
          wr = 1'b1;
          case (f3)
            3'd0: res = a + immi;
            3'd2: res = {31'd0, $signed(a) < $signed(immi)};
            3'd3: res = {31'd0, a < immi};
            3'd4: res = a ^ immi;
            3'd6: res = a | immi;
            3'd7: res = a & immi;
            3'd1: if (f7 == 7'h00) res = a << sh; else wr = 1'b0;
            default: begin
              if (f7 == 7'h00) res = a >> sh;
              else if (f7 == 7'h20) res = $signed(a) >>> sh;
              else wr = 1'b0;
            end
          endcase
        end
        7'h03: if (f3 == 3'd2) begin
          addr = a + immi;
          res  = m_dmem[addr[9:2]];
          wr   = 1'b1;
        end
        7'h23: if (f3 == 3'd2) begin
          addr = a + imms;
          m_dmem[addr[9:2]] = b;
        end
        default: ;
      endcase
      if (wr && rd != 5'd0) begin
        m_regs[rd] = res;
        exp_q.push_back('{rd, res});
      end
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [9:0] rops [10] = '{10'h000, 10'h100, 10'h001, 10'h002,
                              10'h003, 10'h004, 10'h005, 10'h105,
                              10'h006, 10'h007};
    logic [4:0]  rd, rs1, rs2, shamt;
    logic [2:0]  f3;
    logic [11:0] imm;
    logic [31:0] r;
    int sel;
    rd    = 5'($urandom_range(0, 7));
    rs1   = 5'($urandom_range(0, 7));
    rs2   = 5'($urandom_range(0, 7));
    shamt = 5'($urandom_range(0, 31));
    r     = $urandom();
    sel   = int'($urandom_range(0, 9));
    if (sel <= 2) begin
      r[9:0] = rops[$urandom_range(0, 9)];
      return enc_r(r[9:3], rs2, rs1, r[2:0], rd);
    end
    if (sel <= 5) begin
      f3  = 3'($urandom_range(0, 7));
      imm = r[11:0];
      if (f3 == 3'd1) imm = {7'h00, shamt};
      if (f3 == 3'd5) imm = {(r[20] ? 7'h20 : 7'h00), shamt};
      return enc_i(imm, rs1, f3, rd, 7'h13);
    end
    imm = 12'(4 * $urandom_range(0, 7));
    if (sel == 6) return enc_i(imm, 5'd0, 3'd2, rd, 7'h03);
    if (sel == 7) return enc_s(imm, rs2, 5'd0);
    if (sel == 8) return 32'h0;
    case (r[1:0])
      2'd0: return enc_r(7'h01, rs2, rs1, 3'd0, rd);
      2'd1: return enc_i({7'h10, shamt}, rs1, 3'd5, rd, 7'h13);
      2'd2: return {r[31:7], 7'h0B};
      default: return enc_i(imm, 5'd0, 3'd0, rd, 7'h03);
    endcase
  endfunction

  task automatic start_prog();
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    wr_edge.delete();
    for (int i = 0; i < 256; i++)
      dut.imem_inst.mem_array[i] = (i < prog.size()) ? prog[i] : 32'h0;
    model_run();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic finish_prog(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_drain: got %0d writes missing, required 0",
               name, exp_q.size());
    end
    for (int i = 0; i < 32; i++)
      check32($sformatf("%s_x%0d", name, i), get_reg(i), m_regs[i]);
  endtask

  task automatic run_prog(input string name, input int ncyc);
    start_prog();
    repeat (ncyc) @(negedge clk);
    finish_prog(name);
  endtask

  task automatic check_gaps(input string name, input int g1,
                            input int g2);
    checks++;
    if (wr_edge.size() != 3) begin
      failures++;
      $display("FAIL %s: got %0d writes, required 3",
               name, wr_edge.size());
    end else if (wr_edge[1] - wr_edge[0] != g1 ||
                 wr_edge[2] - wr_edge[1] != g2) begin
      failures++;
      $display("FAIL %s: got gaps %0d,%0d, required %0d,%0d", name,
               wr_edge[1] - wr_edge[0], wr_edge[2] - wr_edge[1], g1, g2);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    for (int i = 0; i < 256; i++) m_dmem[i] = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 32; i++)
      check32($sformatf("reset_x%0d", i), get_reg(i), 32'h0);
    check32("reset_we",
            {31'd0, dut.id_stage_inst.reg_file_inst.we}, 32'h0);

    prog = {32'h00A00293, 32'h00528333, 32'h405303B3};
    run_prog("dist1", 10);
    check32("dist1_x5", get_reg(5), 32'd10);
    check32("dist1_x6", get_reg(6), 32'd20);
    check32("dist1_x7", get_reg(7), 32'd10);
    check_gaps("dist1_timing", 1, 1);

    prog = {enc_i(12'd7, 5'd0, 3'd0, 5'd1, 7'h13), 32'h0,
            enc_r(7'h00, 5'd1, 5'd1, 3'd0, 5'd2), 32'h0, 32'h0,
            enc_r(7'h00, 5'd1, 5'd2, 3'd0, 5'd3)};
    run_prog("dist23", 14);
    check32("dist23_x2", get_reg(2), 32'd14);
    check32("dist23_x3", get_reg(3), 32'd21);
    check_gaps("dist23_timing", 2, 3);

    prog = {enc_i(12'd5, 5'd0, 3'd0, 5'd1, 7'h13),
            enc_s(12'd0, 5'd1, 5'd0),
            enc_i(12'd0, 5'd0, 3'd2, 5'd2, 7'h03),
            enc_r(7'h00, 5'd2, 5'd2, 3'd0, 5'd3)};
    run_prog("loaduse", 14);
    check32("loaduse_x3", get_reg(3), 32'd10);
    check_gaps("loaduse_bubble", 2, 2);

    prog = {enc_i(12'd9, 5'd0, 3'd0, 5'd0, 7'h13),
            enc_r(7'h00, 5'd0, 5'd0, 3'd0, 5'd4)};
    run_prog("xzero", 10);
    check32("xzero_x0", get_reg(0), 32'd0);
    check32("xzero_x4", get_reg(4), 32'd0);

    prog = {enc_i(12'd1, 5'd0, 3'd0, 5'd1, 7'h13),
            enc_i(12'd2, 5'd0, 3'd0, 5'd1, 7'h13),
            enc_r(7'h00, 5'd0, 5'd1, 3'd0, 5'd2)};
    run_prog("prio", 10);
    check32("prio_x2", get_reg(2), 32'd2);

    prog = {enc_i(12'hFFF, 5'd0, 3'd0, 5'd3, 7'h13),
            enc_i(12'd28, 5'd3, 3'd5, 5'd4, 7'h13)};
    run_prog("srli", 10);
    check32("srli_x3", get_reg(3), 32'hFFFF_FFFF);
    check32("srli_x4", get_reg(4), 32'h0000_000F);

    for (int t = 0; t < 4; t++) begin
      prog.delete();
      for (int i = 0; i < 24; i++) prog.push_back(rand_instr());
      run_prog($sformatf("rand%0d", t), 58);
    end

    prog = {enc_i(12'd5, 5'd0, 3'd0, 5'd1, 7'h13),
            enc_s(12'd0, 5'd1, 5'd0),
            enc_i(12'd0, 5'd0, 3'd2, 5'd2, 7'h03),
            enc_r(7'h00, 5'd2, 5'd2, 3'd0, 5'd3)};
    start_prog();
    repeat (6) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    bad = 0;
    for (int i = 0; i < 32; i++) if (get_reg(i) !== 32'h0) bad++;
    check32("midreset_regs_zero", 32'(bad), 32'd0);
    bad = 0;
    for (int i = 0; i < 256; i++)
      if (dut.imem_inst.mem_array[i] !==
          ((i < prog.size()) ? prog[i] : 32'h0)) bad++;
    check32("midreset_imem_intact", 32'(bad), 32'd0);
    @(negedge clk);
    exp_q.delete();
    wr_edge.delete();
    model_run();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (14) @(negedge clk);
    finish_prog("midreset_rerun");
    check32("midreset_x3", get_reg(3), 32'd10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
